uart_rx_ctrl: RTL and testbench

//  Frame controller for the UART receiver. Detects the start edge and runs the

---
 rtl/uart_rx_ctrl.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Frame controller for the UART receiver. It detects the start edge, runs the
// oversample (edge) and bit counters that drive data_sampling, checks the
// start, parity and stop bits from the voted sample_bit, and deserialises
// DATA_W data bits LSB-first into P_DATA.
//
// Ports
//   clk          oversampling clock (prescale x baud)
//   reset        asynchronous, active-low
//   RX_IN        synchronised serial input, idle high
//   prescale     oversampling ratio; 8, 16 and 32 are accepted
//   PAR_EN       1 = frame carries a parity bit (latched at start edge)
//   PAR_TYP      0 = even, 1 = odd (latched at start edge)
//   sample_bit   majority-voted bit from data_sampling
//   sample_en    enables data_sampling while a frame is active
//   edge_count   oversample index within the current bit
//   bit_count    0 start, 1-8 data, 9 parity/stop, 10 stop
//   busy         frame in progress
//   P_DATA       last good byte received
//   data_valid   1-cycle pulse, P_DATA updated in the same cycle
//   par_err      1-cycle pulse at frame end on parity mismatch
//   stp_err      1-cycle pulse at frame end when stop bit sampled 0
//   strt_glitch  1-cycle pulse when the start bit samples 1 (frame aborted)
module uart_rx_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RX_IN,
    input  logic [5:0]        prescale,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              sample_bit,
    output logic              sample_en,
    output logic [5:0]        edge_count,
    output logic [3:0]        bit_count,
    output logic              busy,
    output logic [DATA_W-1:0] P_DATA,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic              strt_glitch
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [3:0] LAST_DATA = 4'(DATA_W);

    state_t            state;
    state_t            state_next;
    logic [5:0]        last_edge;
    logic              wrap;
    logic              bit_end;
    logic              prescale_ok;
    logic              par_en_l;
    logic              par_typ_l;
    logic              perr;
    logic [DATA_W-1:0] shreg;

    assign last_edge   = prescale - 6'd1;
    // >= rather than == so a mid-frame prescale drop cannot strand the counter
    assign wrap        = edge_count >= last_edge;
    assign bit_end     = sample_en && (edge_count == last_edge);
    assign prescale_ok = (prescale == 6'd8) || (prescale == 6'd16) || (prescale == 6'd32);

    assign sample_en   = (state != IDLE);
    assign busy        = (state != IDLE);
    assign strt_glitch = (state == START) && bit_end && sample_bit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!RX_IN && prescale_ok) state_next = START;
            end
            START: begin
                if (bit_end) state_next = sample_bit ? IDLE : DATA;
            end
            DATA: begin
                // >= keeps the exit reachable even if bit_count overshoots
                if (bit_end && bit_count >= LAST_DATA) state_next = par_en_l ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters are forced to 0 whenever the frame is (or is about to be) idle,
    // so no stale count is ever visible in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (state == IDLE || state_next == IDLE) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (wrap) begin
            edge_count <= '0;
            bit_count  <= bit_count + 4'd1;
        end else begin
            edge_count <= edge_count + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_en_l   <= 1'b0;
            par_typ_l  <= 1'b0;
            perr       <= 1'b0;
            shreg      <= '0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_next == START) begin
                        par_en_l  <= PAR_EN;
                        par_typ_l <= PAR_TYP;
                        perr      <= 1'b0;
                    end
                end
                DATA: begin
                    if (bit_end) shreg <= {sample_bit, shreg[DATA_W-1:1]};
                end
                PARITY: begin
                    if (bit_end) perr <= (sample_bit != ((^shreg) ^ par_typ_l));
                end
                STOP: begin
                    if (bit_end) begin
                        stp_err <= ~sample_bit;
                        par_err <= perr;
                        if (sample_bit && !perr) begin
                            data_valid <= 1'b1;
                            P_DATA     <= shreg;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
// Drives whole UART frames on RX_IN and emulates data_sampling by presenting
// RX_IN delayed two cycles as sample_bit. Expected pulses, their cycle and
// P_DATA are derived from the frame contents and the frame-length rule.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       sample_bit;
    logic       sample_en;
    logic [5:0] edge_count;
    logic [3:0] bit_count;
    logic       busy;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       strt_glitch;

    logic rx_d1 = 1'b1;
    logic rx_d2 = 1'b1;

    int total = 0;
    int bad = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx_ctrl #(.DATA_W(8)) dut (
        .clk(clk), .reset(reset), .RX_IN(RX_IN), .prescale(prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sample_bit(sample_bit),
        .sample_en(sample_en), .edge_count(edge_count), .bit_count(bit_count),
        .busy(busy), .P_DATA(P_DATA), .data_valid(data_valid),
        .par_err(par_err), .stp_err(stp_err), .strt_glitch(strt_glitch)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rx_d1 <= RX_IN;
        rx_d2 <= rx_d1;
    end
    assign sample_bit = rx_d2;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned all_outs();
        return {8'h00, sample_en, busy, edge_count, bit_count, P_DATA,
                data_valid, par_err, stp_err, strt_glitch};
    endfunction

    // Send one frame. flip_par corrupts the parity bit, stop_bit is the value
    // driven in the stop slot, gap is idle cycles afterwards, rst_at (>=0)
    // asserts reset in that cycle and abandons the frame.
    task automatic frame(input logic [7:0] data, input logic [5:0] p, input bit pen,
                         input bit ptyp, input bit flip_par, input bit stop_bit,
                         input int gap, input int rst_at);
        bit bits[11];
        int n;
        int idx;
        int pulses;
        int end_c;
        bit exp_perr;
        bit good;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        n = 9;
        if (pen) begin
            bits[9] = (^data) ^ ptyp ^ flip_par;
            n = 10;
        end
        bits[n] = stop_bit;
        n++;
        exp_perr = pen && flip_par;
        good     = stop_bit && !exp_perr;
        end_c    = n * int'(p);
        pulses   = 0;
        prescale = p;
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        RX_IN    = 1'b0;
        for (int t = 0; t <= end_c; t++) begin
            step();
            if (t == 0) begin
                chk("start_busy", {busy, sample_en}, 2'b11);
                chk("start_counts", {edge_count, bit_count}, 0);
                // parity settings must already be latched
                PAR_EN  = 1'($urandom);
                PAR_TYP = 1'($urandom);
            end
            if (t == rst_at) begin
                #2 reset = 1'b0;
                #1;
                chk("reset_midframe", all_outs(), 0);
                last_good = 8'h00;
                RX_IN = 1'b1;
                repeat (3) step();
                reset = 1'b1;
                repeat (gap) step();
                return;
            end
            if (t < end_c) begin
                pulses += int'(data_valid) + int'(par_err) + int'(stp_err) + int'(strt_glitch);
            end else begin
                chk("data_valid", data_valid, good);
                chk("par_err", par_err, exp_perr);
                chk("stp_err", stp_err, !stop_bit);
                chk("no_glitch", strt_glitch, 0);
                chk("idle_at_end", busy, 0);
                if (good) last_good = data;
                chk("p_data", P_DATA, last_good);
                chk("early_pulses", pulses, 0);
            end
            idx   = (t + 1) / int'(p);
            RX_IN = (idx < n) ? bits[idx] : 1'b1;
        end
        repeat (gap) step();
    endtask

    task automatic glitch_test();
        int pulses;
        pulses   = 0;
        prescale = 6'd8;
        RX_IN    = 1'b0;
        step();
        RX_IN = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            step();
            if (t < 7) pulses += int'(strt_glitch);
            if (t == 7) begin
                chk("strt_glitch", strt_glitch, 1);
                chk("glitch_alone", {data_valid, par_err, stp_err}, 0);
            end
            if (t == 8) begin
                chk("glitch_idle", {sample_en, busy}, 0);
                chk("glitch_bitcnt", bit_count, 0);
            end
        end
        chk("glitch_early", pulses, 0);
        repeat (3) step();
    endtask

    task automatic illegal_prescale_test();
        int active;
        active   = 0;
        prescale = 6'd12;
        RX_IN    = 1'b0;
        repeat (20) begin
            step();
            active += int'(busy) + int'(sample_en);
        end
        chk("illegal_prescale", active, 0);
        RX_IN = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        int unsigned sel;
        logic [5:0] p;
        reset = 1'b0;
        repeat (3) step();
        chk("reset_state", all_outs(), 0);
        reset = 1'b1;
        step();

        frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 3, -1);
        frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1, 3, -1);
        frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1, 3, -1);
        frame(8'h01, 6'd32, 1'b1, 1'b1, 1'b0, 1'b0, 3, -1);
        glitch_test();
        frame(8'hC3, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 3, 4 * 8 + 4);
        frame(8'h5A, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 3, -1);
        illegal_prescale_test();
        frame(8'h11, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 0, -1);
        frame(8'h22, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 3, -1);

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 2);
            p = (sel == 0) ? 6'd8 : (sel == 1) ? 6'd16 : 6'd32;
            frame(8'($urandom), p, 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
                  $urandom_range(0, 3), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
